// File: rtl/spi_slave_byte_if.sv
// Bus bundle for spi_slave_byte: SPI pins on the master side, word handshake on the core side.
interface spi_slave_byte_if #(
  parameter int unsigned DATABITS = 8
);
  logic                SPI_SCK;
  logic                SPI_CS_n;
  logic                SPI_MOSI;
  logic                SPI_MISO;
  logic                TX_DV;
  logic [DATABITS-1:0] TX_Data;
  logic                RX_DV;
  logic [DATABITS-1:0] RX_Data;
  logic                busy;

  modport slave (
    input  SPI_SCK, SPI_CS_n, SPI_MOSI, TX_DV, TX_Data,
    output SPI_MISO, RX_DV, RX_Data, busy
  );

  modport master (
    output SPI_SCK, SPI_CS_n, SPI_MOSI, TX_DV, TX_Data,
    input  SPI_MISO, RX_DV, RX_Data, busy
  );
endinterface

// File: rtl/spi_slave_byte.sv
// SPI mode-0 slave, MSB first, oversampled by clk; one word per DATABITS SCK cycles.
module spi_slave_byte #(
  parameter int unsigned DATABITS = 8,
  parameter int unsigned SYNC     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_slave_byte_if.slave    bus
);
  localparam int unsigned      CW   = (DATABITS > 1) ? $clog2(DATABITS) : 1;
  localparam logic [CW-1:0]    LAST = CW'(DATABITS - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC-1:0]     sck_sync, cs_sync, mosi_sync;
  logic                sck_d, cs_d;
  logic                sck_s, cs_s, mosi_s;
  logic                sck_rise, sck_fall, cs_rise, cs_fall;

  state_t              state;
  logic [CW-1:0]       bit_cnt;
  logic [DATABITS-1:0] tx_buf, tx_sr, rx_sr, rx_data_q;
  logic                word_done, rx_dv_q, miso_q, busy_q;

  // CS_n chain resets low so a CS_n already low at release never looks like a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC-2:0], bus.SPI_SCK};
      cs_sync   <= {cs_sync[SYNC-2:0], bus.SPI_CS_n};
      mosi_sync <= {mosi_sync[SYNC-2:0], bus.SPI_MOSI};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  always_comb begin
    sck_s    = sck_sync[SYNC-1];
    cs_s     = cs_sync[SYNC-1];
    mosi_s   = mosi_sync[SYNC-1];
    sck_rise = sck_s & ~sck_d;
    sck_fall = ~sck_s & sck_d;
    cs_rise  = cs_s & ~cs_d;
    cs_fall  = ~cs_s & cs_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          tx_buf <= '0;
    else if (bus.TX_DV)  tx_buf <= TX_Data_w();
  end

  function automatic logic [DATABITS-1:0] TX_Data_w();
    return bus.TX_Data;
  endfunction

  // MISO is updated alongside tx_sr so it presents the new MSB in the same clk as the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      word_done <= 1'b0;
      rx_dv_q   <= 1'b0;
      rx_data_q <= '0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_dv_q   <= word_done;
      word_done <= 1'b0;
      if (word_done) rx_data_q <= rx_sr;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= ACTIVE;
            tx_sr   <= tx_buf;
            miso_q  <= tx_buf[DATABITS-1];
            bit_cnt <= '0;
            busy_q  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
            busy_q  <= 1'b0;
            miso_q  <= 1'b0;
          end else if (sck_rise) begin
            rx_sr <= {rx_sr[DATABITS-2:0], mosi_s};
            if (bit_cnt == LAST) begin
              bit_cnt   <= '0;
              word_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sck_fall) begin
            // bit_cnt is back at 0 only after a completed word: reload for back-to-back output.
            if (bit_cnt == '0) begin
              tx_sr  <= tx_buf;
              miso_q <= tx_buf[DATABITS-1];
            end else begin
              tx_sr  <= {tx_sr[DATABITS-2:0], 1'b0};
              miso_q <= tx_sr[DATABITS-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.SPI_MISO = miso_q;
  assign bus.RX_DV    = rx_dv_q;
  assign bus.RX_Data  = rx_data_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_spi_slave_byte.sv
// Self-checking bench for spi_slave_byte: bench acts as SPI master (SCK = clk/8) and models the slave at word level.
module tb_spi_slave_byte;
  localparam int unsigned DB = 8;
  localparam int unsigned SY = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_byte_if #(.DATABITS(DB)) bus ();

  spi_slave_byte #(.DATABITS(DB), .SYNC(SY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {int c; logic [7:0] d;} ev_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dv_cnt = 0;

  ev_t rx_q[$];
  ev_t busy_q[$];
  ev_t miso_q[$];
  logic [7:0] tbuf_hist [int];
  logic [7:0] tbuf_m = '0;
  logic       busy_m = 1'b0;
  logic [7:0] rx_m   = '0;

  logic       rand_tx     = 1'b0;
  logic       tx_dv_fixed = 1'b0;
  logic [7:0] tx_fixed    = '0;

  int         cnt = 0;
  int         load_c = 0;
  logic [7:0] rx_acc = '0;
  logic [7:0] exp_tx = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Core-side stimulus: fixed values or a fresh random TX_Data every clk.
  always @(negedge clk) begin
    if (rand_tx) begin
      bus.TX_Data = 8'($urandom);
      bus.TX_DV   = 1'b1;
    end else begin
      bus.TX_Data = tx_fixed;
      bus.TX_DV   = tx_dv_fixed;
    end
  end

  // Model of tx_buf per clk plus the single per-cycle compare of all outputs.
  always begin
    @(posedge clk);
    cyc++;
    if (!rst_n)         tbuf_m = '0;
    else if (bus.TX_DV) tbuf_m = bus.TX_Data;
    tbuf_hist[cyc] = tbuf_m;
    #1;
    if (busy_q.size() > 0 && busy_q[0].c == cyc) begin
      busy_m = busy_q[0].d[0];
      void'(busy_q.pop_front());
    end
    if (rx_q.size() > 0 && rx_q[0].c == cyc) begin
      chk("rx_dv_pulse", {31'd0, bus.RX_DV}, 32'd1);
      rx_m = rx_q[0].d;
      void'(rx_q.pop_front());
    end else begin
      chk("rx_dv_quiet", {31'd0, bus.RX_DV}, 32'd0);
    end
    chk("rx_data", {24'd0, bus.RX_Data}, {24'd0, rx_m});
    chk("busy", {31'd0, bus.busy}, {31'd0, busy_m});
    if (miso_q.size() > 0 && miso_q[0].c == cyc) begin
      chk("miso_bit", {31'd0, bus.SPI_MISO}, {31'd0, miso_q[0].d[0]});
      void'(miso_q.pop_front());
    end else if (!busy_m) begin
      chk("miso_idle", {31'd0, bus.SPI_MISO}, 32'd0);
    end
    if (bus.RX_DV === 1'b1) dv_cnt++;
  end

  // All master actions happen on the falling clk edge; the slave's latency is SY+1 clk to act.
  task automatic cs_low();
    bus.SPI_CS_n = 1'b0;
    busy_q.push_back('{cyc + int'(SY) + 1, 8'd1});
    cnt    = 0;
    load_c = cyc;
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    bus.SPI_CS_n = 1'b1;
    busy_q.push_back('{cyc + int'(SY) + 1, 8'd0});
    cnt = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] w, input int nbits, output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.SPI_MOSI = w[7-i];
      repeat (4) @(negedge clk);
      if (cnt == 0) exp_tx = tbuf_hist[load_c + int'(SY)];
      miso_q.push_back('{cyc + 1, {7'd0, exp_tx[7-cnt]}});
      got[7-i] = bus.SPI_MISO;
      bus.SPI_SCK = 1'b1;
      rx_acc = {rx_acc[6:0], w[7-i]};
      cnt++;
      if (cnt == 8) rx_q.push_back('{cyc + int'(SY) + 2, rx_acc});
      repeat (4) @(negedge clk);
      bus.SPI_SCK = 1'b0;
      if (cnt == 8) begin
        cnt    = 0;
        load_c = cyc;
      end
    end
  endtask

  initial begin
    logic [7:0] g1, g2;
    int dv0;
    bus.SPI_CS_n = 1'b1;
    bus.SPI_SCK  = 1'b0;
    bus.SPI_MOSI = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_rx_dv",   {31'd0, bus.RX_DV}, 32'd0);
    chk("reset_rx_data", {24'd0, bus.RX_Data}, 32'd0);
    chk("reset_busy",    {31'd0, bus.busy}, 32'd0);
    chk("reset_miso",    {31'd0, bus.SPI_MISO}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single word
    tx_dv_fixed = 1'b1; tx_fixed = 8'h01;
    repeat (3) @(negedge clk);
    dv0 = dv_cnt;
    cs_low(); xfer(8'hA5, 8, g1); cs_high();
    chk("t1_miso_word", {24'd0, g1}, 32'h01);
    chk("t1_rx_data", {24'd0, bus.RX_Data}, 32'hA5);
    chk("t1_dv_count", dv_cnt - dv0, 32'd1);

    // 2: back-to-back
    tx_fixed = 8'h6B;
    repeat (3) @(negedge clk);
    dv0 = dv_cnt;
    cs_low(); xfer(8'h3C, 8, g1); xfer(8'hC3, 8, g2); cs_high();
    chk("t2_dv_count", dv_cnt - dv0, 32'd2);
    chk("t2_rx_data", {24'd0, bus.RX_Data}, 32'hC3);
    chk("t2_miso_w0", {24'd0, g1}, 32'h6B);
    chk("t2_miso_w1", {24'd0, g2}, 32'h6B);

    // 3: abort after 5 bits
    dv0 = dv_cnt;
    cs_low(); xfer(8'hFF, 5, g1); cs_high();
    chk("t3_dv_count", dv_cnt - dv0, 32'd0);
    chk("t3_rx_kept", {24'd0, bus.RX_Data}, 32'hC3);
    chk("t3_busy", {31'd0, bus.busy}, 32'd0);
    cs_low(); xfer(8'h5A, 8, g1); cs_high();
    chk("t3_rx_next", {24'd0, bus.RX_Data}, 32'h5A);

    // 4: tx_buf holds while TX_DV low
    tx_dv_fixed = 1'b1; tx_fixed = 8'h81;
    repeat (3) @(negedge clk);
    tx_dv_fixed = 1'b0; tx_fixed = 8'h00;
    repeat (3) @(negedge clk);
    cs_low(); xfer(8'h33, 8, g1); cs_high();
    chk("t4_miso_word", {24'd0, g1}, 32'h81);

    // 5: reset mid-word
    dv0 = dv_cnt;
    cs_low(); xfer(8'hF0, 4, g1);
    rst_n = 1'b0;
    rx_q.delete(); busy_q.delete(); miso_q.delete();
    busy_m = 1'b0; rx_m = '0; cnt = 0;
    repeat (3) @(negedge clk);
    chk("t5_rx_data", {24'd0, bus.RX_Data}, 32'd0);
    chk("t5_busy", {31'd0, bus.busy}, 32'd0);
    chk("t5_miso", {31'd0, bus.SPI_MISO}, 32'd0);
    bus.SPI_CS_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t5_no_dv", dv_cnt - dv0, 32'd0);
    cs_low(); xfer(8'h96, 8, g1); cs_high();
    chk("t5_rx_next", {24'd0, bus.RX_Data}, 32'h96);
    chk("t5_dv_count", dv_cnt - dv0, 32'd1);

    // 6: random words, TX_Data changing every clk
    rand_tx = 1'b1;
    for (int s = 0; s < 2; s++) begin
      cs_low();
      for (int w = 0; w < 8; w++) xfer(8'($urandom), 8, g1);
      cs_high();
    end
    rand_tx = 1'b0;
    repeat (10) @(negedge clk);
    chk("pending_events", rx_q.size() + busy_q.size() + miso_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
